// File: rtl/snoop_pkg.sv
// Shared types and constants for the snooping-bus arbiter: FSM states,
// bus field widths and default window timing.
package snoop_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Bus word layout: {bus msg, mem msg, tag, data}
    localparam int BUS_W     = 10;
    localparam int BUS_MSG_W = 2;
    localparam int MEM_MSG_W = 2;
    localparam int TAG_W     = 3;
    localparam int DATA_W    = 3;

    localparam int EMIT_CYCLES_DEF  = 7;
    localparam int SNOOP_START_DEF  = 4;
    localparam int SNOOP_CYCLES_DEF = 4;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/snoop_bus_arbiter_rr_pick.sv
// Combinational requester picker. Round-robin from i_ptr by default;
// lowest-index fixed priority when ARB_FIXED_PRIO_EN is defined.
module rr_pick
    import snoop_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0] i_req,
    input  logic [1:0]   i_ptr,
    output logic [1:0]   o_winner,
    output logic         o_valid
);

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        o_valid  = |i_req;
        o_winner = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[k]) o_winner = 2'(k);
        end
    end
`else
    int w_idx;

    // Scanning offsets downward lets the smallest offset from i_ptr win.
    always_comb begin
        o_valid  = |i_req;
        o_winner = '0;
        w_idx    = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = (int'(i_ptr) + k) % N;
            if (i_req[w_idx]) o_winner = 2'(w_idx);
        end
    end
`endif

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Snooping-bus sequencer/arbiter: grants one emitter per transaction, steps
// habilita through the window, owns the bus register. ARB_FIXED_PRIO_EN selects fixed priority.
module snoop_bus_arbiter
    import snoop_pkg::*;
#(
    parameter int N_CPU        = 3,
    parameter int EMIT_CYCLES  = EMIT_CYCLES_DEF,
    parameter int SNOOP_START  = SNOOP_START_DEF,
    parameter int SNOOP_CYCLES = SNOOP_CYCLES_DEF
) (
    input  logic                   i_clock,
    input  logic                   i_clear,
    input  logic [N_CPU-1:0]       i_req,
    input  logic [8*N_CPU-1:0]     i_instr_in,
    output logic [N_CPU-1:0]       o_ack,
    output logic [N_CPU-1:0]       o_habilita,
    output logic [N_CPU-1:0]       o_controleP,
    output logic [7:0]             o_instr_out,
    input  logic [BUS_W*N_CPU-1:0] i_bus_from_cpu,
    input  logic [N_CPU-1:0]       i_shared_from_cpu,
    output logic [BUS_W-1:0]       o_bus_to_cpu,
    output logic                   o_shared_to_cpu,
    output logic                   o_busy,
    output logic [1:0]             o_grant_id
);

    localparam int W     = imax(EMIT_CYCLES, SNOOP_START + SNOOP_CYCLES);
    localparam int CNT_W = $clog2(W) + 1;
    localparam logic [CNT_W-1:0] C_EMIT = CNT_W'(EMIT_CYCLES);
    localparam logic [CNT_W-1:0] C_SS   = CNT_W'(SNOOP_START);
    localparam logic [CNT_W-1:0] C_SE   = CNT_W'(SNOOP_START + SNOOP_CYCLES);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(W - 1);

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [1:0]         r_ptr, w_ptr_nxt;
    logic [N_CPU-1:0]   r_ack, w_ack_nxt;
    logic [N_CPU-1:0]   r_hab, w_hab_nxt;
    logic [N_CPU-1:0]   r_ctl, w_ctl_nxt;
    logic [7:0]         r_instr, w_instr_nxt;
    logic [1:0]         r_grant, w_grant_nxt;
    logic [BUS_W-1:0]   r_bus, w_bus_nxt;
    logic               r_shared, w_shared_nxt;
    logic               r_busy, w_busy_nxt;

    logic [1:0]         w_winner;
    logic               w_valid;
    logic               w_snp_hit;
    logic [1:0]         w_snp_sel;
    logic               w_snp_or;
    logic [BUS_W-1:0]   w_emit_bus;
    logic [BUS_W-1:0]   w_snp_bus;
    logic [7:0]         w_instr_win;

    function automatic logic [N_CPU-1:0] onehot(input logic [1:0] win);
        logic [N_CPU-1:0] v;
        for (int j = 0; j < N_CPU; j++) v[j] = (win == 2'(j));
        return v;
    endfunction

    // Emitter is stepped from the window start; snoopers only inside their slot.
    function automatic logic [N_CPU-1:0] hab_vec(input logic [CNT_W-1:0] c,
                                                 input logic [1:0]       win);
        logic [N_CPU-1:0] v;
        for (int j = 0; j < N_CPU; j++)
            v[j] = (win == 2'(j)) ? (c < C_EMIT) : ((c >= C_SS) && (c < C_SE));
        return v;
    endfunction

    rr_pick #(.N(N_CPU)) u_pick (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_winner(w_winner),
        .o_valid (w_valid)
    );

    // Lowest-index snooper claiming shared owns the reply slot.
    always_comb begin
        w_snp_hit = 1'b0;
        w_snp_sel = '0;
        for (int j = N_CPU - 1; j >= 0; j--) begin
            if (i_shared_from_cpu[j] && (r_grant != 2'(j))) begin
                w_snp_hit = 1'b1;
                w_snp_sel = 2'(j);
            end
        end
    end

    assign w_snp_or    = |(i_shared_from_cpu & ~onehot(r_grant));
    assign w_emit_bus  = i_bus_from_cpu[int'(r_grant)*BUS_W +: BUS_W];
    assign w_snp_bus   = i_bus_from_cpu[int'(w_snp_sel)*BUS_W +: BUS_W];
    assign w_instr_win = i_instr_in[int'(w_winner)*8 +: 8];

    always_ff @(posedge i_clock) begin
        if (!i_clear) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_ptr_nxt    = r_ptr;
        w_ack_nxt    = '0;
        w_hab_nxt    = '0;
        w_ctl_nxt    = r_ctl;
        w_instr_nxt  = r_instr;
        w_grant_nxt  = r_grant;
        w_bus_nxt    = r_bus;
        w_shared_nxt = r_shared;
        w_busy_nxt   = r_busy;
        case (r_state)
            ST_IDLE: begin
                if (w_valid) begin
                    w_ack_nxt   = onehot(w_winner);
                    w_ctl_nxt   = onehot(w_winner);
                    w_instr_nxt = w_instr_win;
                    w_grant_nxt = w_winner;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_cnt_nxt   = '0;
                w_hab_nxt   = hab_vec('0, r_grant);
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (r_cnt < C_SS)   w_bus_nxt = w_emit_bus;
                else if (w_snp_hit) w_bus_nxt = w_snp_bus;
                w_shared_nxt = w_snp_or;
                if (r_cnt == C_LAST) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    w_hab_nxt = hab_vec(r_cnt + 1'b1, r_grant);
                end
            end
            ST_DONE: begin
                w_ctl_nxt    = '0;
                w_busy_nxt   = 1'b0;
                w_shared_nxt = 1'b0;
                w_ptr_nxt    = (r_grant == 2'(N_CPU - 1)) ? 2'd0 : r_grant + 2'd1;
                w_state_nxt  = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_clear) begin
            r_cnt    <= '0;
            r_ptr    <= '0;
            r_ack    <= '0;
            r_hab    <= '0;
            r_ctl    <= '0;
            r_instr  <= '0;
            r_grant  <= '0;
            r_bus    <= '0;
            r_shared <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_ptr    <= w_ptr_nxt;
            r_ack    <= w_ack_nxt;
            r_hab    <= w_hab_nxt;
            r_ctl    <= w_ctl_nxt;
            r_instr  <= w_instr_nxt;
            r_grant  <= w_grant_nxt;
            r_bus    <= w_bus_nxt;
            r_shared <= w_shared_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign o_ack           = r_ack;
    assign o_habilita      = r_hab;
    assign o_controleP     = r_ctl;
    assign o_instr_out     = r_instr;
    assign o_grant_id      = r_grant;
    assign o_bus_to_cpu    = r_bus;
    assign o_shared_to_cpu = r_shared;
    assign o_busy          = r_busy;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Bench for snoop_bus_arbiter: transaction-timeline model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_snoop_bus_arbiter;

    localparam int N  = 3;
    localparam int EC = 7;
    localparam int SS = 4;
    localparam int SC = 4;
    localparam int W  = 8;

    logic           clk = 1'b0;
    logic           clear = 1'b0;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] instr_in = '0;
    logic [10*N-1:0] bus_from = '0;
    logic [N-1:0]   shared_from = '0;
    logic [N-1:0]   o_ack, o_habilita, o_controleP;
    logic [7:0]     o_instr_out;
    logic [9:0]     o_bus_to_cpu;
    logic           o_shared_to_cpu, o_busy;
    logic [1:0]     o_grant_id;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 0;

    snoop_bus_arbiter dut (
        .i_clock(clk), .i_clear(clear), .i_req(req), .i_instr_in(instr_in),
        .o_ack(o_ack), .o_habilita(o_habilita), .o_controleP(o_controleP),
        .o_instr_out(o_instr_out), .i_bus_from_cpu(bus_from),
        .i_shared_from_cpu(shared_from), .o_bus_to_cpu(o_bus_to_cpu),
        .o_shared_to_cpu(o_shared_to_cpu), .o_busy(o_busy), .o_grant_id(o_grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: m_age counts cycles since the ack became visible (-1 = idle).
    // age 0 setup, ages 1..W run window step age-1, age W+1 wrap-up.
    int         m_age = -1, m_win = 0, m_ptr = 0;
    logic [7:0] m_instr = '0;
    logic [9:0] m_bus = '0;
    logic       m_shared = 1'b0;

    always @(posedge clk) begin
        int k, sel;
        if (!clear) begin
            m_age = -1; m_win = 0; m_ptr = 0; m_instr = '0; m_bus = '0; m_shared = 1'b0;
        end else if (m_age < 0) begin
            if (req != 0) begin
                for (int o = N - 1; o >= 0; o--)
                    if (req[(m_ptr + o) % N]) m_win = (m_ptr + o) % N;
                m_instr = instr_in[8*m_win +: 8];
                m_age   = 0;
            end
        end else begin
            if (m_age >= 1 && m_age <= W) begin
                k = m_age - 1;
                if (k < SS) m_bus = bus_from[10*m_win +: 10];
                else begin
                    sel = -1;
                    for (int j = N - 1; j >= 0; j--)
                        if (j != m_win && shared_from[j]) sel = j;
                    if (sel >= 0) m_bus = bus_from[10*sel +: 10];
                end
                m_shared = 1'b0;
                for (int j = 0; j < N; j++)
                    if (j != m_win && shared_from[j]) m_shared = 1'b1;
            end
            if (m_age == W + 1) begin
                m_shared = 1'b0;
                m_ptr    = (m_win + 1) % N;
                m_age    = -1;
            end else m_age++;
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] e_ack, e_ctl, e_hab;
        int k;
        if (chk_en) begin
            e_ack = '0; e_ctl = '0; e_hab = '0;
            if (m_age >= 0) e_ctl[m_win] = 1'b1;
            if (m_age == 0) e_ack[m_win] = 1'b1;
            if (m_age >= 1 && m_age <= W) begin
                k = m_age - 1;
                for (int j = 0; j < N; j++)
                    e_hab[j] = (j == m_win) ? (k < EC) : (k >= SS && k < SS + SC);
            end
            chk("ack", o_ack, e_ack);
            chk("controleP", o_controleP, e_ctl);
            chk("habilita", o_habilita, e_hab);
            chk("busy", o_busy, m_age >= 0);
            chk("instr_out", o_instr_out, m_instr);
            chk("grant_id", o_grant_id, (m_age < 0 && m_instr == 0 && m_win == 0) ? 2'd0 : 2'(m_win));
            chk("bus_to_cpu", o_bus_to_cpu, m_bus);
            chk("shared_to_cpu", o_shared_to_cpu, m_shared);
        end
    end

    task automatic wait_ack(output int cyc);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (o_ack == 0 && cyc < 30);
        if (o_ack == 0) begin
            n_chk++; n_err++;
            $display("FAIL ack_timeout actual=none required=ack within 30 cycles");
        end
    endtask

    task automatic wait_idle();
        int c = 0;
        while (o_busy && c < 30) begin @(negedge clk); c++; end
        @(negedge clk);
        if (o_busy) begin
            n_chk++; n_err++;
            $display("FAIL idle_timeout actual=busy required=idle within 30 cycles");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, ctlcnt, c;
        bit a2;
        int gid[$];
        int gt[$];

        // reset
        repeat (2) @(negedge clk);
        chk_en = 1;
        chk("reset_outputs", {o_ack, o_habilita, o_controleP, o_instr_out, o_bus_to_cpu,
                              o_shared_to_cpu, o_busy, o_grant_id}, 32'd0);
        clear = 1'b1;
        @(negedge clk);

        // single request from CPU1
        req = 3'b010;
        instr_in[15:8] = 8'b10_011_101;
        wait_ack(cyc);
        chk("single_ack_latency", cyc, 1);
        chk("single_ack", o_ack, 3'b010);
        chk("single_instr", o_instr_out, 8'h9D);
        chk("single_ctl", o_controleP, 3'b010);
        req = '0;
        ctlcnt = 1; c = 1;
        while (o_busy && c < 30) begin
            @(negedge clk); c++;
            if (o_controleP != 0) ctlcnt++;
        end
        chk("single_ctl_cycles", ctlcnt, 10);
        chk("single_busy_fall", c, 11);

        // snoop response: CPU0 emits, CPU2 answers shared at step 5
        bus_from[9:0] = 10'h0A3;
        req = 3'b001;
        wait_ack(cyc);
        req = '0;
        repeat (4) @(negedge clk);
        chk("snoop_emit_bus", o_bus_to_cpu, 10'h0A3);
        repeat (2) @(negedge clk);
        shared_from[2] = 1'b1;
        bus_from[29:20] = 10'h11B;
        repeat (2) @(negedge clk);
        chk("snoop_reply_bus", o_bus_to_cpu, 10'h11B);
        chk("snoop_shared", o_shared_to_cpu, 1'b1);
        wait_idle();
        shared_from = '0;
        bus_from[29:20] = '0;

        // withdrawn request during a busy transaction
        req = 3'b010;
        instr_in[15:8] = 8'h5A;
        wait_ack(cyc);
        chk("withdraw_grant", o_grant_id, 2'd1);
        req = '0;
        repeat (3) @(negedge clk);
        req = 3'b100;
        instr_in[23:16] = 8'hFF;
        @(negedge clk);
        req = '0;
        a2 = 0; c = 0;
        while (o_busy && c < 30) begin @(negedge clk); c++; a2 |= o_ack[2]; end
        repeat (2) @(negedge clk);
        a2 |= o_ack[2];
        chk("withdraw_no_ack2", a2, 1'b0);
        chk("withdraw_instr_hold", o_instr_out, 8'h5A);

        // reset in the middle of the run window
        req = 3'b001;
        wait_ack(cyc);
        req = '0;
        repeat (4) @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        chk("midrun_reset_outputs", {o_ack, o_habilita, o_controleP, o_instr_out, o_bus_to_cpu,
                                     o_shared_to_cpu, o_busy, o_grant_id}, 32'd0);
        clear = 1'b1;
        req = 3'b100;
        wait_ack(cyc);
        chk("post_reset_ack", o_ack, 3'b100);
        chk("post_reset_grant", o_grant_id, 2'd2);
        req = '0;
        wait_idle();

        // contention: all requesting continuously
        bus_from = {10'h2C4, 10'h155, 10'h0A3};
        req = 3'b111;
        c = 0;
        while (gid.size() < 4 && c < 80) begin
            @(negedge clk); c++;
            if (o_ack != 0) begin gid.push_back(int'(o_grant_id)); gt.push_back(c); end
        end
        req = '0;
        if (gid.size() < 4) begin
            n_chk++; n_err++;
            $display("FAIL contention_grants actual=%0d required=4", gid.size());
        end else begin
            chk("rr_grant0", gid[0], 0);
            chk("rr_grant1", gid[1], 1);
            chk("rr_grant2", gid[2], 2);
            chk("rr_grant3", gid[3], 0);
            for (int i = 1; i < 4; i++) chk("rr_spacing", gt[i] - gt[i-1], 11);
        end
        wait_idle();

        // idle hold: bus register keeps its value while inputs move
        bus_from = '1;
        repeat (20) @(negedge clk);
        chk("idle_bus_hold", o_bus_to_cpu, 10'h0A3);
        chk("idle_ctl", o_controleP, 3'b000);
        chk("idle_hab", o_habilita, 3'b000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
